bsg_wormhole_traffic_node: RTL

Single-clock, parametrised wormhole traffic node for router testbenches. It generates variable-length request packets with sequence numbers and echoes received requests back as responses. It checks returning responses for in-order sequence, coordinates and payload, and throttles traffic with an outstanding-packet credit limit. It connects directly to one router port: a forward (request) link pair and a reverse (response) link pair.

---
 rtl/bsg_wormhole_traffic_node.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_wormhole_traffic_node.sv
// bsg_wormhole_traffic_node: wormhole request generator, request echo
// responder and in-order response checker for router testbenches.
// Ports:
//   clk_i, reset_n_i            : clock, synchronous active-low reset
//   en_i, len_i                 : request start enable, body flits of next request
//   my_cord_i, dest_cord_i      : own coordinate, request target / response source
//   fwd_v_o/fwd_data_o/fwd_ready_and_i : outgoing requests
//   fwd_v_i/fwd_data_i/fwd_ready_and_o : incoming requests (echoed)
//   rev_v_o/rev_data_o/rev_ready_and_i : outgoing responses
//   rev_v_i/rev_data_i/rev_ready_and_o : incoming responses (checked)
//   sent_o, received_o, outstanding_o  : traffic counters
//   error_o, err_code_o                : sticky first error (1 cord, 2 seq, 3 payload)
module bsg_wormhole_traffic_node #(
    parameter int flit_width_p      = 32,
    parameter int cord_width_p      = 4,
    parameter int len_width_p       = 4,
    parameter int max_outstanding_p = 4,
    parameter int seq_width_p       = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   en_i,
    input  logic [cord_width_p-1:0]                my_cord_i,
    input  logic [cord_width_p-1:0]                dest_cord_i,
    input  logic [len_width_p-1:0]                 len_i,
    output logic                                   fwd_v_o,
    output logic [flit_width_p-1:0]                fwd_data_o,
    input  logic                                   fwd_ready_and_i,
    input  logic                                   fwd_v_i,
    input  logic [flit_width_p-1:0]                fwd_data_i,
    output logic                                   fwd_ready_and_o,
    output logic                                   rev_v_o,
    output logic [flit_width_p-1:0]                rev_data_o,
    input  logic                                   rev_ready_and_i,
    input  logic                                   rev_v_i,
    input  logic [flit_width_p-1:0]                rev_data_i,
    output logic                                   rev_ready_and_o,
    output logic [31:0]                            sent_o,
    output logic [31:0]                            received_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   error_o,
    output logic [1:0]                             err_code_o
);

    localparam int out_width_lp = $clog2(max_outstanding_p+1);
    localparam int len_lsb_lp   = cord_width_p;
    localparam int src_lsb_lp   = cord_width_p + len_width_p;
    localparam int seq_lsb_lp   = 2*cord_width_p + len_width_p;
    localparam int hdr_width_lp = seq_lsb_lp + seq_width_p;

    localparam logic [1:0] GEN_IDLE = 2'd0;
    localparam logic [1:0] GEN_HDR  = 2'd1;
    localparam logic [1:0] GEN_BODY = 2'd2;

    localparam logic [0:0] CHK_HDR  = 1'b0;
    localparam logic [0:0] CHK_BODY = 1'b1;

    localparam logic [len_width_p-1:0] len_one_lp = len_width_p'(1);

    function automatic logic [flit_width_p-1:0] make_hdr(
        input logic [cord_width_p-1:0] dest,
        input logic [len_width_p-1:0]  len,
        input logic [cord_width_p-1:0] src,
        input logic [seq_width_p-1:0]  seq
    );
        logic [hdr_width_lp-1:0] h;
        h = {seq, src, len, dest};
        return flit_width_p'(h);
    endfunction

    function automatic logic [flit_width_p-1:0] make_body(
        input logic [seq_width_p-1:0] seq,
        input logic [len_width_p-1:0] k
    );
        logic [seq_width_p+7:0] b;
        b = {seq, 8'(k)};
        return flit_width_p'(b);
    endfunction

    // generator state
    logic [1:0]              gen_state_q, gen_state_d;
    logic [len_width_p-1:0]  gen_len_q, gen_len_d;
    logic [len_width_p-1:0]  gen_cnt_q, gen_cnt_d;
    logic [seq_width_p-1:0]  gen_seq_q, gen_seq_d;
    logic [seq_width_p-1:0]  tx_seq_q, tx_seq_d;
    logic [flit_width_p-1:0] fwd_data_q, fwd_data_d;
    logic [31:0]             sent_q, sent_d;

    // echo fifo state
    logic [flit_width_p-1:0] fifo_mem_q [2];
    logic [flit_width_p-1:0] fifo_mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    echo_hdr_q, echo_hdr_d;
    logic [len_width_p-1:0]  echo_rem_q, echo_rem_d;

    // checker state
    logic [0:0]              chk_state_q, chk_state_d;
    logic [len_width_p-1:0]  chk_len_q, chk_len_d;
    logic [len_width_p-1:0]  chk_cnt_q, chk_cnt_d;
    logic [seq_width_p-1:0]  chk_seq_q, chk_seq_d;
    logic [seq_width_p-1:0]  exp_seq_q, exp_seq_d;
    logic [31:0]             recv_q, recv_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;

    logic [out_width_lp-1:0] out_q, out_d;
    logic                    rdy_q;

    logic                    fwd_hs, gen_hdr_hs, gen_last_hs;
    logic                    can_start, start;
    logic                    push, pop;
    logic [flit_width_p-1:0] echo_flit;
    logic                    rx_hs, rx_last;
    logic [len_width_p-1:0]  rx_len;
    logic [cord_width_p-1:0] rx_dest, rx_src;
    logic [seq_width_p-1:0]  rx_seq;
    logic [1:0]              rx_code;

    assign fwd_v_o         = (gen_state_q != GEN_IDLE);
    assign fwd_data_o      = fwd_data_q;
    assign fwd_ready_and_o = rdy_q & (fifo_cnt_q != 2'd2);
    assign rev_v_o         = (fifo_cnt_q != 2'd0);
    assign rev_data_o      = fifo_mem_q[rd_ptr_q];
    assign rev_ready_and_o = rdy_q;
    assign sent_o          = sent_q;
    assign received_o      = recv_q;
    assign outstanding_o   = out_q;
    assign error_o         = err_q;
    assign err_code_o      = code_q;

    assign fwd_hs      = fwd_v_o & fwd_ready_and_i;
    assign gen_hdr_hs  = fwd_hs & (gen_state_q == GEN_HDR);
    assign gen_last_hs = fwd_hs
                       & (((gen_state_q == GEN_HDR) & (gen_len_q == '0))
                       | ((gen_state_q == GEN_BODY)
                       & (gen_cnt_q == gen_len_q - len_one_lp)));

    assign push = fwd_v_i & fwd_ready_and_o;
    assign pop  = rev_v_o & rev_ready_and_i;

    assign rx_hs   = rev_v_i & rdy_q;
    assign rx_dest = rev_data_i[0 +: cord_width_p];
    assign rx_len  = rev_data_i[len_lsb_lp +: len_width_p];
    assign rx_src  = rev_data_i[src_lsb_lp +: cord_width_p];
    assign rx_seq  = rev_data_i[seq_lsb_lp +: seq_width_p];
    assign rx_last = rx_hs
                   & ((chk_state_q == CHK_HDR) ? (rx_len == '0)
                                               : (chk_cnt_q == chk_len_q - len_one_lp));

    // outstanding credits: taken at header handshake, returned on last response flit
    always_comb begin
        out_d = out_q;
        if (gen_hdr_hs && !rx_last) begin
            out_d = out_q + out_width_lp'(1);
        end else if (!gen_hdr_hs && rx_last && (out_q != '0)) begin
            out_d = out_q - out_width_lp'(1);
        end
    end

    // generator
    always_comb begin
        gen_state_d = gen_state_q;
        gen_len_d   = gen_len_q;
        gen_cnt_d   = gen_cnt_q;
        gen_seq_d   = gen_seq_q;
        fwd_data_d  = fwd_data_q;
        tx_seq_d    = gen_hdr_hs ? tx_seq_q + seq_width_p'(1) : tx_seq_q;
        sent_d      = gen_last_hs ? sent_q + 32'd1 : sent_q;
        // out_d already holds this cycle's credit change, so a back-to-back
        // start can never exceed the limit
        can_start   = en_i & (out_d < out_width_lp'(max_outstanding_p));
        start       = 1'b0;
        unique case (gen_state_q)
            GEN_IDLE: start = can_start;
            GEN_HDR: begin
                if (fwd_hs) begin
                    if (gen_len_q != '0) begin
                        gen_state_d = GEN_BODY;
                        gen_cnt_d   = '0;
                        fwd_data_d  = make_body(gen_seq_q, '0);
                    end else begin
                        gen_state_d = GEN_IDLE;
                        start       = can_start;
                    end
                end
            end
            GEN_BODY: begin
                if (fwd_hs) begin
                    if (gen_cnt_q == gen_len_q - len_one_lp) begin
                        gen_state_d = GEN_IDLE;
                        start       = can_start;
                    end else begin
                        gen_cnt_d  = gen_cnt_q + len_one_lp;
                        fwd_data_d = make_body(gen_seq_q, gen_cnt_q + len_one_lp);
                    end
                end
            end
            default: gen_state_d = GEN_IDLE;
        endcase
        if (start) begin
            gen_state_d = GEN_HDR;
            gen_len_d   = len_i;
            gen_seq_d   = tx_seq_d;
            fwd_data_d  = make_hdr(dest_cord_i, len_i, my_cord_i, tx_seq_d);
        end
    end

    // echo fifo: headers are readdressed back to their source on the way in
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        echo_hdr_d = echo_hdr_q;
        echo_rem_d = echo_rem_q;
        echo_flit  = fwd_data_i;
        if (echo_hdr_q) begin
            echo_flit[0 +: cord_width_p]          = fwd_data_i[src_lsb_lp +: cord_width_p];
            echo_flit[src_lsb_lp +: cord_width_p] = my_cord_i;
        end
        if (push) begin
            fifo_mem_d[wr_ptr_q] = echo_flit;
            wr_ptr_d             = ~wr_ptr_q;
            if (echo_hdr_q) begin
                if (fwd_data_i[len_lsb_lp +: len_width_p] != '0) begin
                    echo_hdr_d = 1'b0;
                    echo_rem_d = fwd_data_i[len_lsb_lp +: len_width_p];
                end
            end else begin
                echo_rem_d = echo_rem_q - len_one_lp;
                if (echo_rem_q == len_one_lp) begin
                    echo_hdr_d = 1'b1;
                end
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // response checker
    always_comb begin
        chk_state_d = chk_state_q;
        chk_len_d   = chk_len_q;
        chk_cnt_d   = chk_cnt_q;
        chk_seq_d   = chk_seq_q;
        exp_seq_d   = exp_seq_q;
        recv_d      = rx_last ? recv_q + 32'd1 : recv_q;
        err_d       = err_q;
        code_d      = code_q;
        rx_code     = 2'd0;
        if (rx_hs) begin
            unique case (chk_state_q)
                CHK_HDR: begin
                    exp_seq_d = exp_seq_q + seq_width_p'(1);
                    if ((rx_dest != my_cord_i) || (rx_src != dest_cord_i)) begin
                        rx_code = 2'd1;
                    end else if (rx_seq != exp_seq_q) begin
                        rx_code = 2'd2;
                    end
                    if (rx_len != '0) begin
                        chk_state_d = CHK_BODY;
                        chk_len_d   = rx_len;
                        chk_cnt_d   = '0;
                        chk_seq_d   = rx_seq;
                    end
                end
                CHK_BODY: begin
                    if (rev_data_i != make_body(chk_seq_q, chk_cnt_q)) begin
                        rx_code = 2'd3;
                    end
                    chk_cnt_d = chk_cnt_q + len_one_lp;
                    if (chk_cnt_q == chk_len_q - len_one_lp) begin
                        chk_state_d = CHK_HDR;
                    end
                end
                default: chk_state_d = CHK_HDR;
            endcase
        end
        if ((rx_code != 2'd0) && !err_q) begin
            err_d  = 1'b1;
            code_d = rx_code;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            gen_state_q   <= GEN_IDLE;
            gen_len_q     <= '0;
            gen_cnt_q     <= '0;
            gen_seq_q     <= '0;
            tx_seq_q      <= '0;
            fwd_data_q    <= '0;
            sent_q        <= '0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= '0;
            echo_hdr_q    <= 1'b1;
            echo_rem_q    <= '0;
            chk_state_q   <= CHK_HDR;
            chk_len_q     <= '0;
            chk_cnt_q     <= '0;
            chk_seq_q     <= '0;
            exp_seq_q     <= '0;
            recv_q        <= '0;
            err_q         <= 1'b0;
            code_q        <= '0;
            out_q         <= '0;
            rdy_q         <= 1'b0;
        end else begin
            gen_state_q   <= gen_state_d;
            gen_len_q     <= gen_len_d;
            gen_cnt_q     <= gen_cnt_d;
            gen_seq_q     <= gen_seq_d;
            tx_seq_q      <= tx_seq_d;
            fwd_data_q    <= fwd_data_d;
            sent_q        <= sent_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            echo_hdr_q    <= echo_hdr_d;
            echo_rem_q    <= echo_rem_d;
            chk_state_q   <= chk_state_d;
            chk_len_q     <= chk_len_d;
            chk_cnt_q     <= chk_cnt_d;
            chk_seq_q     <= chk_seq_d;
            exp_seq_q     <= exp_seq_d;
            recv_q        <= recv_d;
            err_q         <= err_d;
            code_q        <= code_d;
            out_q         <= out_d;
            rdy_q         <= 1'b1;
        end
    end

endmodule
